vc_rr_arbiter: RTL and testbench

- Round-robin arbiter that drains four source FIFOs (fifo_d0-style: pop/empty interface, data registered one cycle after pop).
- Routes each popped word to one of two destination FIFOs (d0/d1), selected by the word's MSB.
- Backpressure comes from the destination pause flags; sits between the virtual-channel FIFO stage and the d0/d1 FIFO stage.

---
 rtl/vc_rr_arbiter.sv | 114 +++++++++++
 tb/tb_vc_rr_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/vc_rr_arbiter.sv
// Round-robin drain of four source FIFOs into the d0/d1 destination FIFOs, steered by word MSB.
// Optional push counters cnt_d0/cnt_d1 are built when VC_RR_ARBITER_STATS_EN is defined.
module vc_rr_arbiter #(
  parameter int DATA_SIZE = 6,
  parameter int NUM_REQ   = 4
) (
  input  logic                         clk,
  input  logic                         reset_L,
  input  logic [NUM_REQ-1:0]           fifo_empty,
  input  logic [NUM_REQ-1:0]           fifo_error,
  input  logic [NUM_REQ*DATA_SIZE-1:0] data_in,
  input  logic                         pause_d0,
  input  logic                         pause_d1,
  output logic [NUM_REQ-1:0]           pop,
  output logic                         push_d0,
  output logic                         push_d1,
  output logic [DATA_SIZE-1:0]         data_out,
  output logic [1:0]                   arb_state,
  output logic                         error_sticky
`ifdef VC_RR_ARBITER_STATS_EN
  ,
  output logic [7:0]                   cnt_d0,
  output logic [7:0]                   cnt_d1
`endif
);

  // state  | meaning
  // IDLE   | all sources empty, nothing to pop
  // ACTIVE | at least one source non-empty, pops allowed when unpaused
  // PAUSE  | a destination is almost full, pops blocked
  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] ACTIVE = 2'b01;
  localparam logic [1:0] PAUSE  = 2'b10;

  logic [1:0]           state_q, state_d;
  logic [1:0]           rr_ptr;
  logic [1:0]           gnt_idx;
  logic                 gnt_found;
  logic                 gnt_valid;
  logic                 pause_any;
  logic                 push_valid_q;
  logic [1:0]           push_idx_q;
  logic [DATA_SIZE-1:0] data_hold_q;
  logic [DATA_SIZE-1:0] sel_word;

  assign pause_any = pause_d0 | pause_d1;
  assign arb_state = state_q;

  always_ff @(posedge clk) begin
    if (!reset_L) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = IDLE;
    if (state_q == 2'b11)     state_d = IDLE;
    else if (pause_any)       state_d = PAUSE;
    else if (|(~fifo_empty))  state_d = ACTIVE;
    else                      state_d = IDLE;
  end

  // First non-empty source at or after rr_ptr; the 2-bit index wraps modulo 4.
  always_comb begin
    gnt_idx   = rr_ptr;
    gnt_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_found && !fifo_empty[2'(rr_ptr + 2'(k))]) begin
        gnt_idx   = 2'(rr_ptr + 2'(k));
        gnt_found = 1'b1;
      end
    end
  end

  always_comb begin
    gnt_valid = (state_q == ACTIVE) && !pause_any && gnt_found;
    pop       = '0;
    if (gnt_valid) pop[gnt_idx] = 1'b1;
  end

  // Source data appears the cycle after its pop, so route it with the registered grant.
  assign sel_word = data_in[int'(push_idx_q)*DATA_SIZE +: DATA_SIZE];
  assign push_d0  = push_valid_q & ~sel_word[DATA_SIZE-1];
  assign push_d1  = push_valid_q &  sel_word[DATA_SIZE-1];
  assign data_out = push_valid_q ? sel_word : data_hold_q;

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      rr_ptr       <= 2'd0;
      push_valid_q <= 1'b0;
      push_idx_q   <= 2'd0;
      data_hold_q  <= '0;
      error_sticky <= 1'b0;
    end else begin
      if (gnt_valid) rr_ptr <= 2'(gnt_idx + 2'd1);
      push_valid_q <= gnt_valid;
      push_idx_q   <= gnt_idx;
      if (push_valid_q) data_hold_q <= sel_word;
      error_sticky <= error_sticky | (|fifo_error);
    end
  end

`ifdef VC_RR_ARBITER_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      cnt_d0 <= 8'd0;
      cnt_d1 <= 8'd0;
    end else begin
      if (push_d0 && cnt_d0 != 8'hFF) cnt_d0 <= cnt_d0 + 8'd1;
      if (push_d1 && cnt_d1 != 8'hFF) cnt_d1 <= cnt_d1 + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vc_rr_arbiter.sv
// Directed bench for vc_rr_arbiter: a cycle model predicts pops and queues the push each pop owes.
module tb_vc_rr_arbiter;
  localparam int DS = 6;
  localparam int NR = 4;

  logic              clk = 1'b0;
  logic              reset_L;
  logic [NR-1:0]     fifo_empty;
  logic [NR-1:0]     fifo_error;
  logic [NR*DS-1:0]  data_in;
  logic              pause_d0, pause_d1;
  logic [NR-1:0]     pop;
  logic              push_d0, push_d1;
  logic [DS-1:0]     data_out;
  logic [1:0]        arb_state;
  logic              error_sticky;
`ifdef VC_RR_ARBITER_STATS_EN
  logic [7:0]        cnt_d0, cnt_d1;
  int                m_cnt0, m_cnt1;
`endif

  vc_rr_arbiter #(.DATA_SIZE(DS), .NUM_REQ(NR)) dut (
    .clk(clk), .reset_L(reset_L), .fifo_empty(fifo_empty), .fifo_error(fifo_error),
    .data_in(data_in), .pause_d0(pause_d0), .pause_d1(pause_d1), .pop(pop),
    .push_d0(push_d0), .push_d1(push_d1), .data_out(data_out), .arb_state(arb_state),
    .error_sticky(error_sticky)
`ifdef VC_RR_ARBITER_STATS_EN
    , .cnt_d0(cnt_d0), .cnt_d1(cnt_d1)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { bit v; int src; } ent_t;
  ent_t sb_q[$];

  int        n_cmp = 0;
  int        n_err = 0;
  bit        chk_en = 1'b0;
  logic [1:0] m_state = 2'b00;
  int        m_ptr = 0;
  logic [DS-1:0] m_hold = '0;
  logic      m_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DS-1:0] src_word(input int s);
    logic [NR*DS-1:0] d;
    d = data_in;
    return d[s*DS +: DS];
  endfunction

  // One clock: check outputs at the negedge, advance the model, then step past the posedge.
  task automatic cycle();
    ent_t e, nx;
    logic [NR-1:0] exp_pop;
    logic [DS-1:0] w;
    int g;
    bit found;
    @(negedge clk);
    e = '{v: 1'b0, src: 0};
    if (sb_q.size() > 0) e = sb_q.pop_front();
    found = 1'b0;
    g = 0;
    exp_pop = '0;
    if (m_state == 2'b01 && !(pause_d0 | pause_d1)) begin
      for (int k = 0; k < NR; k++) begin
        if (!found && !fifo_empty[(m_ptr + k) % NR]) begin
          g = (m_ptr + k) % NR;
          found = 1'b1;
        end
      end
    end
    if (found) exp_pop[g] = 1'b1;
    w = e.v ? src_word(e.src) : m_hold;
    if (chk_en) begin
      chk("pop", 32'(pop), 32'(exp_pop));
      chk("arb_state", 32'(arb_state), 32'(m_state));
      chk("push_d0", 32'(push_d0), 32'(e.v & ~w[DS-1]));
      chk("push_d1", 32'(push_d1), 32'(e.v & w[DS-1]));
      chk("data_out", 32'(data_out), 32'(w));
      chk("error_sticky", 32'(error_sticky), 32'(m_err));
`ifdef VC_RR_ARBITER_STATS_EN
      chk("cnt_d0", 32'(cnt_d0), 32'(m_cnt0));
      chk("cnt_d1", 32'(cnt_d1), 32'(m_cnt1));
`endif
    end
    nx = '{v: found, src: g};
    @(posedge clk);
    #1;
    if (!reset_L) begin
      m_state = 2'b00; m_ptr = 0; m_hold = '0; m_err = 1'b0;
      sb_q.delete();
      sb_q.push_back('{v: 1'b0, src: 0});
`ifdef VC_RR_ARBITER_STATS_EN
      m_cnt0 = 0; m_cnt1 = 0;
`endif
    end else begin
      if (e.v) m_hold = w;
`ifdef VC_RR_ARBITER_STATS_EN
      if (e.v && !w[DS-1] && m_cnt0 < 255) m_cnt0++;
      if (e.v &&  w[DS-1] && m_cnt1 < 255) m_cnt1++;
`endif
      m_err = m_err | (|fifo_error);
      if (found) m_ptr = (g + 1) % NR;
      if (pause_d0 | pause_d1)  m_state = 2'b10;
      else if (|(~fifo_empty))  m_state = 2'b01;
      else                      m_state = 2'b00;
      sb_q.push_back(nx);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    reset_L = 1'b0; fifo_empty = 4'hF; fifo_error = '0; data_in = '0;
    pause_d0 = 1'b0; pause_d1 = 1'b0;
    run(2);
    chk_en = 1'b1;
    reset_L = 1'b1;
    run(5);

    // sources 0 and 2 alternate, one to each destination
    data_in = {6'h3F, 6'h21, 6'h0A, 6'h05};
    fifo_empty = 4'b1010;
    run(8);
    fifo_empty = 4'hF;
    run(2);

    reset_L = 1'b0; run(1); reset_L = 1'b1;
    fifo_empty = 4'h0;
    run(7);

    pause_d1 = 1'b1; run(3);
    pause_d1 = 1'b0; run(4);
    pause_d0 = 1'b1; run(1);
    pause_d0 = 1'b0; run(3);

    reset_L = 1'b0; run(1); reset_L = 1'b1;
    run(4);

    fifo_error = 4'b0100; run(1);
    fifo_error = 4'b0000; run(3);
    reset_L = 1'b0; run(1); reset_L = 1'b1;
    run(2);

    for (int i = 0; i < 40; i++) begin
      fifo_empty = 4'($urandom_range(0, 15));
      data_in    = 24'($urandom);
      pause_d0   = ($urandom_range(0, 5) == 0);
      pause_d1   = ($urandom_range(0, 5) == 0);
      reset_L    = ($urandom_range(0, 19) != 0);
      run(1);
    end
    reset_L = 1'b1; pause_d0 = 1'b0; pause_d1 = 1'b0;

`ifdef VC_RR_ARBITER_STATS_EN
    reset_L = 1'b0; run(1); reset_L = 1'b1;
    data_in = {6'h3F, 6'h21, 6'h0A, 6'h05};
    fifo_empty = 4'b1110;
    run(310);
    chk("cnt_d0_sat", 32'(cnt_d0), 32'd255);
`endif
    fifo_empty = 4'hF;
    run(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
